mem_port_arbiter: RTL

//  Round-robin arbiter sharing one strobe/done memory port (128-bit line

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the requester-side and memory-side buses of mem_port_arbiter.
//   Requester k owns slice k of every per-requester bus.
//
//   Requester side : req_i, req_rw_i, req_addr_i, req_wdata_i  (to arbiter)
//                    req_rdata_o, req_done_o                    (from arbiter)
//   Memory side    : mem_strobe_o, mem_rw_o, mem_addr_o,
//                    mem_wdata_o                                (from arbiter)
//                    mem_rdata_i, mem_done_i                    (to arbiter)
//   Status         : grant_o, busy_o                            (from arbiter)
//
//   master : the arbiter itself
//   slave  : everything around it (caches + memory model / controller)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]            req_i;
  logic [N_REQ-1:0]            req_rw_i;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [N_REQ*DATA_WIDTH-1:0] req_wdata_i;
  logic [N_REQ*DATA_WIDTH-1:0] req_rdata_o;
  logic [N_REQ-1:0]            req_done_o;

  logic                        mem_strobe_o;
  logic                        mem_rw_o;
  logic [ADDR_WIDTH-1:0]       mem_addr_o;
  logic [DATA_WIDTH-1:0]       mem_wdata_o;
  logic [DATA_WIDTH-1:0]       mem_rdata_i;
  logic                        mem_done_i;

  logic [IDX_W-1:0]            grant_o;
  logic                        busy_o;

  modport master (
    input  req_i, req_rw_i, req_addr_i, req_wdata_i, mem_rdata_i, mem_done_i,
    output req_rdata_o, req_done_o, mem_strobe_o, mem_rw_o, mem_addr_o,
           mem_wdata_o, grant_o, busy_o
  );

  modport slave (
    output req_i, req_rw_i, req_addr_i, req_wdata_i, mem_rdata_i, mem_done_i,
    input  req_rdata_o, req_done_o, mem_strobe_o, mem_rw_o, mem_addr_o,
           mem_wdata_o, grant_o, busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Round-robin arbiter sharing one strobe/done memory port among N_REQ cache
//   requesters. One transfer at a time: IDLE picks a requester and latches its
//   command, ISSUE pulses the downstream strobe, WAIT holds the command until
//   mem_done_i, COOL pulses the requester's done bit and gives the downstream
//   one recovery cycle before the next strobe.
//
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : mem_port_arbiter_if.master (requester buses, memory port, status)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COOL
  } state_e;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]            grant_q, grant_d;
  logic                        mem_rw_q, mem_rw_d;
  logic [ADDR_WIDTH-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
  logic [N_REQ*DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [N_REQ-1:0]            done_q, done_d;

  // Round-robin pick: scan offsets from the far end down to 0 so that the
  // smallest offset from rr_ptr (the highest-priority requester) is written
  // last and wins.
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_i[(int'(rr_ptr_q) + i) % N_REQ]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'((int'(rr_ptr_q) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    // NOTE: every *_d gets a default first so no path through the case leaves a latch.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    done_d      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d     = pick_idx;
          mem_rw_d    = bus.req_rw_i[pick_idx];
          mem_addr_d  = bus.req_addr_i[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d = bus.req_wdata_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: state_d = S_WAIT;

      S_WAIT: begin
        if (bus.mem_done_i) begin
          if (!mem_rw_q) begin
            rdata_d[grant_q*DATA_WIDTH +: DATA_WIDTH] = bus.mem_rdata_i;
          end
          // Registered done: set on the way into COOL so it is high exactly
          // during the COOL cycle.
          done_d[grant_q] = 1'b1;
          state_d         = S_COOL;
        end
      end

      S_COOL: begin
        rr_ptr_d = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      // NOTE: the per-requester read lines are ordinary flops, not a RAM, so reset clears them too.
      rdata_q     <= '0;
      done_q      <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
    end
  end

  // Strobe is a decode of the state flop: high for the single ISSUE cycle.
  assign bus.mem_strobe_o = (state_q == S_ISSUE);
  assign bus.busy_o       = (state_q != S_IDLE);
  assign bus.mem_rw_o     = mem_rw_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;
  assign bus.req_rdata_o  = rdata_q;
  assign bus.req_done_o   = done_q;
  assign bus.grant_o      = grant_q;

endmodule
